// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver with 16x oversampling, majority voting and a FWFT frame FIFO.
module uart_rx_fifo #(
  parameter int MaxDataBits = 9,
  parameter int DivWidth    = 16,
  parameter int FifoDepth   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_in,
  input  logic [DivWidth-1:0]          cfg_div,
  input  logic [3:0]                   cfg_data_bits,
  input  logic [1:0]                   cfg_parity,
  input  logic                         cfg_two_stop,
  output logic [MaxDataBits-1:0]       m_data,
  output logic                         m_parity_err,
  output logic                         m_frame_err,
  output logic                         m_break,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         overrun,
  output logic [$clog2(FifoDepth):0]   fifo_count
);

  localparam int AW = $clog2(FifoDepth);
  localparam int CW = AW + 1;
  localparam int EW = MaxDataBits + 3;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t                  state;
  logic [1:0]              sync;
  logic                    rx_s;
  logic [DivWidth-1:0]     pre, div_l;
  logic [3:0]              tcnt, bit_cnt, bits_l;
  logic                    par_en, par_odd, two_l;
  logic                    s7, s8, maj, tick, samp;
  logic [MaxDataBits-1:0]  shreg, bit_mask;
  logic                    par_acc, any_one, fe_acc, brk1, stop2nd;
  logic                    brk_now, fe_now;
  logic                    push;
  logic [EW-1:0]           push_entry;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], rx_in};
  end
  assign rx_s = sync[1];

  assign tick     = (pre >= div_l - DivWidth'(1));
  assign samp     = tick && (tcnt == 4'd9);
  assign maj      = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);
  assign bit_mask = MaxDataBits'(1) << bit_cnt;
  // Break is judged on the first stop bit; with two stop bits it was captured in brk1.
  assign brk_now  = stop2nd ? brk1 : (!any_one && !maj);
  assign fe_now   = fe_acc | !maj;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pre        <= '0;
      div_l      <= DivWidth'(1);
      tcnt       <= '0;
      bit_cnt    <= '0;
      bits_l     <= 4'd8;
      par_en     <= 1'b0;
      par_odd    <= 1'b0;
      two_l      <= 1'b0;
      s7         <= 1'b1;
      s8         <= 1'b1;
      shreg      <= '0;
      par_acc    <= 1'b0;
      any_one    <= 1'b0;
      fe_acc     <= 1'b0;
      brk1       <= 1'b0;
      stop2nd    <= 1'b0;
      push       <= 1'b0;
      push_entry <= '0;
    end else begin
      push <= 1'b0;
      if (state != IDLE) begin
        if (tick) begin
          pre  <= '0;
          tcnt <= tcnt + 4'd1;
          if (tcnt == 4'd7) s7 <= rx_s;
          if (tcnt == 4'd8) s8 <= rx_s;
        end else begin
          pre <= pre + DivWidth'(1);
        end
      end
      case (state)
        IDLE: if (!rx_s) begin
          pre     <= '0;
          tcnt    <= '0;
          div_l   <= (cfg_div == '0) ? DivWidth'(1) : cfg_div;
          bits_l  <= cfg_data_bits;
          par_en  <= (cfg_parity == 2'd1) || (cfg_parity == 2'd2);
          par_odd <= (cfg_parity == 2'd2);
          two_l   <= cfg_two_stop;
          shreg   <= '0;
          par_acc <= 1'b0;
          any_one <= 1'b0;
          fe_acc  <= 1'b0;
          brk1    <= 1'b0;
          stop2nd <= 1'b0;
          bit_cnt <= '0;
          state   <= START;
        end
        START: if (samp) state <= maj ? IDLE : DATA;
        DATA: if (samp) begin
          if (maj) shreg <= shreg | bit_mask;
          par_acc <= par_acc ^ maj;
          any_one <= any_one | maj;
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt + 4'd1 >= bits_l) state <= par_en ? PARITY : STOP;
        end
        PARITY: if (samp) begin
          par_acc <= par_acc ^ maj;
          any_one <= any_one | maj;
          state   <= STOP;
        end
        STOP: if (samp) begin
          if (two_l && !stop2nd) begin
            stop2nd <= 1'b1;
            fe_acc  <= !maj;
            brk1    <= !any_one && !maj;
          end else begin
            push <= 1'b1;
            if (brk_now) push_entry <= {3'b100, {MaxDataBits{1'b0}}};
            else         push_entry <= {1'b0, fe_now, par_en & (par_acc ^ par_odd), shreg};
            state <= (brk_now || fe_now) ? BRK_WAIT : IDLE;
          end
        end
        BRK_WAIT: if (rx_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  logic [EW-1:0] mem [FifoDepth];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, full, wr_en;
  logic [EW-1:0] head;

  assign m_valid = (fifo_count != '0);
  assign pop     = m_valid && m_ready;
  assign full    = (fifo_count == CW'(FifoDepth));
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign wr_en   = push && (!full || pop);
  assign head    = m_valid ? mem[rd_ptr] : '0;
  assign {m_break, m_frame_err, m_parity_err, m_data} = head;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - scoreboard bench for uart_rx_fifo with a frame-level reference model.
module tb_uart_rx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_in = 1'b1;
  logic [15:0] cfg_div = 16'd4;
  logic [3:0]  cfg_data_bits = 4'd8;
  logic [1:0]  cfg_parity = 2'd0;
  logic        cfg_two_stop = 1'b0;
  logic [8:0]  m_data;
  logic        m_parity_err, m_frame_err, m_break, m_valid, overrun;
  logic        m_ready = 1'b0;
  logic [2:0]  fifo_count;

  uart_rx_fifo dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .cfg_div(cfg_div),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_two_stop(cfg_two_stop),
    .m_data(m_data), .m_parity_err(m_parity_err), .m_frame_err(m_frame_err),
    .m_break(m_break), .m_valid(m_valid), .m_ready(m_ready), .overrun(overrun),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int ovr_cnt = 0;
  int rise_cyc = 0;
  int frame_c0 = 0;
  int rdy_mode = 1;
  logic [11:0] exp_q[$];
  logic [11:0] head, prev_head;
  logic        prev_v = 1'b0, prev_r = 1'b0;

  assign head = {m_break, m_frame_err, m_parity_err, m_data};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected entry from the frame as sent on the wire: {break, frame_err, parity_err, data}.
  function automatic logic [11:0] ref_frame(input int bits, input int par, input bit two,
                                            input logic [8:0] d, input bit p, input bit s1, input bit s2);
    int mask;
    logic [8:0] dm;
    bit en, odd, brk, perr, ferr;
    mask = (1 << bits) - 1;
    dm   = d & mask[8:0];
    en   = (par == 1) || (par == 2);
    odd  = (par == 2);
    brk  = (dm == 0) && (!en || !p) && !s1;
    if (brk) return {1'b1, 2'b00, 9'd0};
    perr = en ? ((^dm) ^ p ^ odd) : 1'b0;
    ferr = !s1 || (two && !s2);
    return {1'b0, ferr, perr, dm};
  endfunction

  task automatic send_frame(input int div, input int bits, input int par, input bit two,
                            input logic [8:0] d, input bit bad_par, input bit s1, input bit s2,
                            input bit expect_push);
    bit q[$];
    int mask, per;
    logic [8:0] dm;
    bit en, p;
    mask = (1 << bits) - 1;
    dm   = d & mask[8:0];
    en   = (par == 1) || (par == 2);
    p    = (^dm) ^ (par == 2) ^ bad_par;
    per  = 16 * ((div == 0) ? 1 : div);
    if (expect_push) exp_q.push_back(ref_frame(bits, par, two, dm, en ? p : 1'b0, s1, s2));
    q.push_back(1'b0);
    for (int i = 0; i < bits; i++) q.push_back(dm[i]);
    if (en) q.push_back(p);
    q.push_back(s1);
    if (two) q.push_back(s2);
    @(posedge clk); #1;
    cfg_div       = div[15:0];
    cfg_data_bits = bits[3:0];
    cfg_parity    = par[1:0];
    cfg_two_stop  = two;
    frame_c0      = cyc;
    foreach (q[i]) begin
      rx_in = q[i];
      repeat (per) @(posedge clk);
      #1;
    end
    rx_in = 1'b1;
    repeat (2 * per) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       m_ready = 1'b0;
      1:       m_ready = 1'b1;
      default: m_ready = ($urandom_range(3) != 0);
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (m_valid && !prev_v) rise_cyc = cyc;
      if (prev_v && !prev_r) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_head", head, prev_head);
      end
      if (overrun) ovr_cnt++;
      if (m_valid && m_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop actual=%0h expected=none", head);
        end else begin
          chk("entry", head, exp_q.pop_front());
        end
      end
    end
    prev_v    = m_valid;
    prev_r    = m_ready;
    prev_head = head;
  end

  initial begin
    int pc0;
    repeat (3) @(negedge clk);
    chk("rst_valid", m_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_data", m_data, 0);
    chk("rst_flags", {m_break, m_frame_err, m_parity_err}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);

    rdy_mode = 1;
    send_frame(4, 8, 0, 0, 9'h0A5, 0, 1, 1, 1);
    chk("latency", rise_cyc - frame_c0, 620);
    drain();

    send_frame(4, 7, 1, 1, 9'h041, 1, 1, 1, 1);
    drain();

    pc0 = pop_cnt;
    @(posedge clk); #1;
    rx_in = 1'b0;
    repeat (24) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (192) @(posedge clk);
    chk("false_start_pops", pop_cnt - pc0, 0);
    chk("false_start_count", fifo_count, 0);
    send_frame(4, 8, 0, 0, 9'h0C3, 0, 1, 1, 1);
    drain();

    pc0 = pop_cnt;
    exp_q.push_back({1'b1, 2'b00, 9'd0});
    @(posedge clk); #1;
    cfg_div = 16'd4; cfg_data_bits = 4'd8; cfg_parity = 2'd0; cfg_two_stop = 1'b0;
    rx_in = 1'b0;
    repeat (20 * 64) @(posedge clk);
    #1;
    chk("break_pops", pop_cnt - pc0, 1);
    rx_in = 1'b1;
    repeat (128) @(posedge clk);
    chk("break_no_more", pop_cnt - pc0, 1);
    send_frame(4, 8, 0, 0, 9'h05A, 0, 1, 1, 1);
    drain();

    rdy_mode = 0;
    repeat (3) @(posedge clk);
    send_frame(2, 8, 0, 0, 9'h011, 0, 1, 1, 1);
    send_frame(2, 8, 1, 0, 9'h022, 0, 1, 1, 1);
    send_frame(2, 6, 2, 1, 9'h033, 0, 1, 1, 1);
    send_frame(2, 9, 0, 0, 9'h144, 0, 1, 1, 1);
    chk("ovr_none_yet", ovr_cnt, 0);
    send_frame(2, 8, 0, 0, 9'h055, 0, 1, 1, 0);
    chk("full_count", fifo_count, 4);
    chk("ovr_once", ovr_cnt, 1);
    rdy_mode = 1;
    drain();

    @(posedge clk); #1;
    cfg_div = 16'd4; cfg_data_bits = 4'd8; cfg_parity = 2'd0; cfg_two_stop = 1'b0;
    rx_in = 1'b0;
    repeat (64) @(posedge clk);
    #1;
    rx_in = 1'b1;
    repeat (64) @(posedge clk);
    #1;
    rx_in = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rx_in = 1'b1;
    rst = 1'b0;
    repeat (640) @(posedge clk);
    chk("midrst_count", fifo_count, 0);
    send_frame(4, 8, 0, 0, 9'h03C, 0, 1, 1, 1);
    drain();

    rdy_mode = 2;
    for (int n = 0; n < 24; n++) begin
      int div, bits, par, kind;
      logic [8:0] d;
      bit two, badp, s1, s2;
      div  = $urandom_range(3);
      bits = $urandom_range(9, 5);
      par  = $urandom_range(3);
      two  = $urandom_range(1);
      d    = 9'($urandom);
      kind = $urandom_range(9);
      badp = (kind == 1) || (kind == 2);
      s1   = !(kind == 3);
      s2   = !(kind == 4);
      if (kind == 5) begin
        d = 9'd0;
        s1 = 1'b0;
      end
      send_frame(div, bits, par, two, d, badp, s1, s2, 1);
    end
    rdy_mode = 1;
    drain();
    chk("ovr_total", ovr_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
